multicycle_control_unit: RTL and testbench

- Parametrised successor control unit for the multi-cycle RISC core.
- Owns a stage-sequencing FSM (IF→ID→EX→MEM→WB) and decodes instruction type, function code and zero flag into registered datapath control signals.
- Adds per-instruction variable path length, a data-memory ready handshake with timeout, and illegal-opcode detection.
- Sits between the instruction register/flag register and all stage-enable/mux inputs of the datapath.

---
 rtl/cu_pkg.sv | 23 ++
 rtl/multicycle_control_unit_if.sv | 40 ++++
 rtl/cu_decoder.sv | 74 +++++++
 rtl/multicycle_control_unit.sv | 102 ++++++++++
 tb/tb_multicycle_control_unit.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// cu_pkg: shared encodings for the multi-cycle control unit
//   state_t   : stage-sequencing FSM states
//   itype_t   : instruction type field codes (R/S/I/J)
//   F_*       : function code values within each instruction type
//   PC_*/RB_* : sig_pc_src / sig_rb_src encodings
//   path_t    : decoder path flags steering the FSM
package cu_pkg;
    typedef enum logic [2:0] {S_RST, S_IF, S_ID, S_EX, S_MEM, S_WB} state_t;
    typedef enum logic [1:0] {T_R = 2'b00, T_S = 2'b01, T_I = 2'b10, T_J = 2'b11} itype_t;
    localparam int unsigned F_ANDI = 0, F_ADDI = 1, F_LW = 2, F_SW = 3, F_BEQ = 4;
    localparam int unsigned F_SLL = 0, F_SLR = 1;
    localparam int unsigned F_J = 0, F_JAL = 1, F_RET = 2;
    localparam logic [1:0] PC_NEXT = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_RET = 2'd3;
    localparam logic [1:0] RB_RS2 = 2'd0, RB_RD = 2'd1, RB_IMM = 2'd2;
    typedef struct packed {
        logic ex;
        logic mem;
        logic wb;
        logic store;
        logic branch;
        logic illegal;
    } path_t;
endpackage

// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if: control unit <-> datapath signal bundle
//   master : control unit side (takes instruction/flag/ready, drives controls and stage enables)
//   slave  : datapath side
interface multicycle_control_unit_if #(
    parameter int FUNC_W   = 5,
    parameter int ALU_OP_W = 3
);
    logic [1:0]          instr_type;
    logic [FUNC_W-1:0]   func_code;
    logic                flag_zero;
    logic                mem_ready;
    logic [ALU_OP_W-1:0] sig_alu_op;
    logic [1:0]          sig_pc_src;
    logic [1:0]          sig_rb_src;
    logic                sig_rf_enable_write;
    logic                sig_enable_data_memory_write;
    logic                sig_enable_data_memory_read;
    logic                sig_write_back_data_select;
    logic                en_instruction_fetch;
    logic                en_instruction_decode;
    logic                en_execute;
    logic                en_memory_access;
    logic                en_write_back;
    logic                illegal_instr;
    logic                mem_timeout;
    modport master (
        input  instr_type, func_code, flag_zero, mem_ready,
        output sig_alu_op, sig_pc_src, sig_rb_src, sig_rf_enable_write,
               sig_enable_data_memory_write, sig_enable_data_memory_read, sig_write_back_data_select,
               en_instruction_fetch, en_instruction_decode, en_execute, en_memory_access, en_write_back,
               illegal_instr, mem_timeout
    );
    modport slave (
        output instr_type, func_code, flag_zero, mem_ready,
        input  sig_alu_op, sig_pc_src, sig_rb_src, sig_rf_enable_write,
               sig_enable_data_memory_write, sig_enable_data_memory_read, sig_write_back_data_select,
               en_instruction_fetch, en_instruction_decode, en_execute, en_memory_access, en_write_back,
               illegal_instr, mem_timeout
    );
endinterface

// File: rtl/cu_decoder.sv
// cu_decoder: combinational decode of {instr_type, func_code} into controls and path flags
//   instr_type, func_code : instruction fields
//   alu_op, pc_src, rb_src, wb_sel : datapath controls for the decoded op
//   path : which stages the op visits, store/branch kind, illegal flag
module cu_decoder
    import cu_pkg::*;
#(
    parameter int FUNC_W   = 5,
    parameter int ALU_OP_W = 3
) (
    input  logic [1:0]          instr_type,
    input  logic [FUNC_W-1:0]   func_code,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          pc_src,
    output logic [1:0]          rb_src,
    output logic                wb_sel,
    output path_t               path
);
    int unsigned f;
    always_comb begin
        f = 32'(func_code);
        alu_op = '0;
        pc_src = PC_NEXT;
        rb_src = RB_RS2;
        wb_sel = 1'b0;
        path = '0;
        case (itype_t'(instr_type))
            T_R: if (f < 8) begin
                alu_op = ALU_OP_W'(f);
                {path.ex, path.wb} = 2'b11;
            end
            T_S: if (f == F_SLL || f == F_SLR) begin
                alu_op = ALU_OP_W'(4 + f);
                {path.ex, path.wb} = 2'b11;
            end
            T_I: case (f)
                F_ANDI, F_ADDI: begin
                    alu_op = ALU_OP_W'(f);
                    rb_src = RB_IMM;
                    {path.ex, path.wb} = 2'b11;
                end
                F_LW: begin
                    alu_op = ALU_OP_W'(1);
                    rb_src = RB_IMM;
                    wb_sel = 1'b1;
                    {path.ex, path.mem, path.wb} = 3'b111;
                end
                F_SW: begin
                    alu_op = ALU_OP_W'(1);
                    rb_src = RB_RD;
                    {path.ex, path.mem, path.store} = 3'b111;
                end
                F_BEQ: begin
                    alu_op = ALU_OP_W'(2);
                    rb_src = RB_RD;
                    {path.ex, path.branch} = 2'b11;
                end
                default: ;
            endcase
            T_J: case (f)
                F_J: pc_src = PC_JUMP;
                F_JAL: begin
                    pc_src = PC_JUMP;
                    path.wb = 1'b1;
                end
                F_RET: pc_src = PC_RET;
                default: ;
            endcase
            default: ;
        endcase
        // every legal op either uses EX/WB or redirects the PC
        path.illegal = !(path.ex || path.wb || pc_src != PC_NEXT);
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: IF/ID/EX/MEM/WB sequencer with registered datapath controls
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : master side of multicycle_control_unit_if (instruction fields, zero flag,
//             mem_ready in; ALU/mux controls, strobes, one-hot stage enables,
//             illegal_instr / mem_timeout pulses out)
module multicycle_control_unit
    import cu_pkg::*;
#(
    parameter int FUNC_W      = 5,
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input logic                         clock,
    input logic                         reset_n,
    multicycle_control_unit_if.master   bus
);
    state_t              state;
    logic [TO_W-1:0]     to_cnt;
    logic [ALU_OP_W-1:0] d_alu_op, alu_op_q;
    logic [1:0]          d_pc_src, d_rb_src, pc_src_q, rb_src_q;
    logic                d_wb_sel, wb_sel_q, mem_q, wb_q, store_q, br_q, illegal_q, timeout_q;
    path_t               d_path;

    cu_decoder #(.FUNC_W(FUNC_W), .ALU_OP_W(ALU_OP_W)) u_dec (
        .instr_type(bus.instr_type),
        .func_code (bus.func_code),
        .alu_op    (d_alu_op),
        .pc_src    (d_pc_src),
        .rb_src    (d_rb_src),
        .wb_sel    (d_wb_sel),
        .path      (d_path)
    );

    // controls are captured on ID exit and held until the next ID exit;
    // only BEQ updates pc_src again, on EX exit. The two pulses are
    // registered, so they appear in the cycle after the deciding edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_RST;
            to_cnt <= '0;
            alu_op_q <= '0;
            pc_src_q <= PC_NEXT;
            rb_src_q <= RB_RS2;
            wb_sel_q <= 1'b0;
            {mem_q, wb_q, store_q, br_q} <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            case (state)
                S_RST: state <= S_IF;
                S_IF:  state <= S_ID;
                S_ID: begin
                    alu_op_q <= d_alu_op;
                    pc_src_q <= d_pc_src;
                    rb_src_q <= d_rb_src;
                    wb_sel_q <= d_wb_sel;
                    {mem_q, wb_q, store_q, br_q} <= {d_path.mem, d_path.wb, d_path.store, d_path.branch};
                    illegal_q <= d_path.illegal;
                    state <= d_path.ex ? S_EX : d_path.wb ? S_WB : S_IF;
                end
                S_EX: begin
                    if (br_q) pc_src_q <= bus.flag_zero ? PC_BRANCH : PC_NEXT;
                    state <= mem_q ? S_MEM : wb_q ? S_WB : S_IF;
                end
                S_MEM: begin
                    if (bus.mem_ready) begin
                        to_cnt <= '0;
                        state <= wb_q ? S_WB : S_IF;
                    end else if (to_cnt == TO_W'(MEM_TIMEOUT)) begin
                        to_cnt <= '0;
                        timeout_q <= 1'b1;
                        state <= S_IF;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_WB:    state <= S_IF;
                default: state <= S_RST;
            endcase
        end
    end

    // enables and strobes decode only the state flops, so reset clears them at once
    assign bus.en_instruction_fetch         = state == S_IF;
    assign bus.en_instruction_decode        = state == S_ID;
    assign bus.en_execute                   = state == S_EX;
    assign bus.en_memory_access             = state == S_MEM;
    assign bus.en_write_back                = state == S_WB;
    assign bus.sig_rf_enable_write          = state == S_WB;
    assign bus.sig_enable_data_memory_write = state == S_MEM && store_q;
    assign bus.sig_enable_data_memory_read  = state == S_MEM && !store_q;
    assign bus.sig_alu_op                   = alu_op_q;
    assign bus.sig_pc_src                   = pc_src_q;
    assign bus.sig_rb_src                   = rb_src_q;
    assign bus.sig_write_back_data_select   = wb_sel_q;
    assign bus.illegal_instr                = illegal_q;
    assign bus.mem_timeout                  = timeout_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench replaying per-cycle expected traces
module tb_multicycle_control_unit;
    localparam int FUNC_W = 5, ALU_OP_W = 3, MEM_TIMEOUT = 15, TO_W = 4;

    typedef struct packed {
        logic [4:0] en;
        logic       rf, mw, mr, wbs, ill, to;
        logic [1:0] pc, rb;
        logic [2:0] alu;
        logic       rdy;
    } rec_t;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    multicycle_control_unit_if #(.FUNC_W(FUNC_W), .ALU_OP_W(ALU_OP_W)) bus ();

    multicycle_control_unit #(
        .FUNC_W(FUNC_W), .ALU_OP_W(ALU_OP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    rec_t        sb[$];
    int          passed = 0, failed = 0, total = 0;
    logic [1:0]  cur_it;
    logic [4:0]  cur_fn;
    logic        cur_fz;
    string       cur_tag;
    logic [1:0]  p_pc = 2'd0, p_rb = 2'd0;
    logic [2:0]  p_alu = 3'd0;
    logic        p_wbs = 1'b0, p_ill = 1'b0, p_to = 1'b0;

    function automatic logic [4:0] obs_en();
        return {bus.en_write_back, bus.en_memory_access, bus.en_execute,
                bus.en_instruction_decode, bus.en_instruction_fetch};
    endfunction

    function automatic logic [2:0] obs_str();
        return {bus.sig_rf_enable_write, bus.sig_enable_data_memory_write, bus.sig_enable_data_memory_read};
    endfunction

    function automatic logic [7:0] obs_ctl();
        return {bus.sig_pc_src, bus.sig_rb_src, bus.sig_alu_op, bus.sig_write_back_data_select};
    endfunction

    function automatic logic [17:0] obs_all();
        return {obs_en(), obs_str(), bus.illegal_instr, bus.mem_timeout, obs_ctl()};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected behaviour written from the instruction table and stage latencies
    task automatic build(input logic [1:0] it, input logic [4:0] fn, input logic fz, input int waits);
        rec_t r;
        logic ex = 0, mem = 0, wb = 0, st = 0, br = 0, wbs = 0, legal = 1, abort;
        logic [1:0] pc = 0, rb = 0;
        logic [2:0] alu = 0;
        int n;
        case (it)
            2'b00: if (fn < 8) begin ex = 1; wb = 1; alu = fn[2:0]; end else legal = 0;
            2'b01: if (fn < 2) begin ex = 1; wb = 1; alu = 3'd4 + fn[2:0]; end else legal = 0;
            2'b10: case (fn)
                5'd0, 5'd1: begin ex = 1; wb = 1; alu = fn[2:0]; rb = 2; end
                5'd2: begin ex = 1; mem = 1; wb = 1; alu = 1; rb = 2; wbs = 1; end
                5'd3: begin ex = 1; mem = 1; st = 1; alu = 1; rb = 1; end
                5'd4: begin ex = 1; br = 1; alu = 2; rb = 1; end
                default: legal = 0;
            endcase
            default: case (fn)
                5'd0: pc = 2;
                5'd1: begin pc = 2; wb = 1; end
                5'd2: pc = 3;
                default: legal = 0;
            endcase
        endcase
        r = '0;
        r.rdy = 1'b1;
        r.en = 5'b00001;
        {r.pc, r.rb, r.alu, r.wbs, r.ill, r.to} = {p_pc, p_rb, p_alu, p_wbs, p_ill, p_to};
        sb.push_back(r);
        r.en = 5'b00010;
        {r.ill, r.to} = 2'b00;
        sb.push_back(r);
        {r.pc, r.rb, r.alu, r.wbs} = {pc, rb, alu, wbs};
        if (ex) begin
            r.en = 5'b00100;
            sb.push_back(r);
        end
        abort = mem && waits > MEM_TIMEOUT;
        if (mem) begin
            n = abort ? MEM_TIMEOUT + 1 : waits + 1;
            r.en = 5'b01000;
            {r.mw, r.mr} = {st, !st};
            for (int k = 0; k < n; k++) begin
                r.rdy = !abort && k == n - 1;
                sb.push_back(r);
            end
            {r.mw, r.mr, r.rdy} = 3'b001;
        end
        if (wb && !abort) begin
            r.en = 5'b10000;
            r.rf = 1'b1;
            sb.push_back(r);
        end
        p_pc = br ? {1'b0, fz} : pc;
        {p_rb, p_alu, p_wbs, p_ill, p_to} = {rb, alu, wbs, !legal, abort};
    endtask

    task automatic drain(input int n);
        rec_t r;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            r = sb.pop_front();
            chk($sformatf("%s.c%0d.en", cur_tag, i), 32'(obs_en()), 32'(r.en));
            chk($sformatf("%s.c%0d.strobes", cur_tag, i), 32'(obs_str()), 32'({r.rf, r.mw, r.mr}));
            chk($sformatf("%s.c%0d.pulses", cur_tag, i), 32'({bus.illegal_instr, bus.mem_timeout}), 32'({r.ill, r.to}));
            chk($sformatf("%s.c%0d.ctl", cur_tag, i), 32'(obs_ctl()), 32'({r.pc, r.rb, r.alu, r.wbs}));
            if (r.en == 5'b00001) begin
                bus.instr_type = cur_it;
                bus.func_code = cur_fn;
                bus.flag_zero = cur_fz;
            end
            bus.mem_ready = r.rdy;
        end
    endtask

    task automatic run_instr(input string tag, input logic [1:0] it, input logic [4:0] fn,
                             input logic fz, input int waits);
        cur_tag = tag;
        {cur_it, cur_fn, cur_fz} = {it, fn, fz};
        build(it, fn, fz, waits);
        drain(sb.size());
    endtask

    initial begin
        bus.instr_type = 2'b00;
        bus.func_code = 5'd1;
        bus.flag_zero = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (2) begin
            @(negedge clock);
            chk("reset.all", 32'(obs_all()), 32'd0);
        end
        reset_n = 1'b1;
        run_instr("r_add",      2'b00, 5'd1, 1'b0, 0);
        run_instr("lw_wait3",   2'b10, 5'd2, 1'b0, 3);
        run_instr("beq_z1",     2'b10, 5'd4, 1'b1, 0);
        run_instr("beq_z0",     2'b10, 5'd4, 1'b0, 0);
        run_instr("sw_timeout", 2'b10, 5'd3, 1'b0, 99);
        run_instr("j_illegal",  2'b11, 5'd7, 1'b0, 0);
        run_instr("jal",        2'b11, 5'd1, 1'b0, 0);
        run_instr("s_slr",      2'b01, 5'd1, 1'b0, 0);
        run_instr("i_addi",     2'b10, 5'd1, 1'b0, 0);
        run_instr("i_andi",     2'b10, 5'd0, 1'b1, 0);
        run_instr("ret",        2'b11, 5'd2, 1'b0, 0);
        run_instr("r_illegal",  2'b00, 5'd8, 1'b0, 0);
        run_instr("j",          2'b11, 5'd0, 1'b0, 0);
        run_instr("r_func7",    2'b00, 5'd7, 1'b0, 0);
        run_instr("lw_ready0",  2'b10, 5'd2, 1'b0, 0);
        run_instr("sw_wait2",   2'b10, 5'd3, 1'b0, 2);
        cur_tag = "sw_rst";
        {cur_it, cur_fn, cur_fz} = {2'b10, 5'd3, 1'b0};
        build(2'b10, 5'd3, 1'b0, 99);
        drain(4);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_async.wr", 32'(bus.sig_enable_data_memory_write), 32'd0);
        chk("rst_async.en_mem", 32'(bus.en_memory_access), 32'd0);
        chk("rst_async.all", 32'(obs_all()), 32'd0);
        sb.delete();
        @(negedge clock);
        chk("rst_hold.all", 32'(obs_all()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
